// File: rtl/count_pwm_3bit_if.sv
// Duty-update handshake between a duty source and count_pwm_3bit.
// Latency: none, wires only.
// Backpressure: duty_ready low means the consumer's one-entry buffer is full.
//
// Ports (signals):
//   duty_in    : requested duty in counts per period, 0..2^CNT_W (wider values clamp)
//   duty_valid : duty_in is offered this cycle
//   duty_ready : consumer can take a duty value this cycle
interface count_pwm_3bit_if #(
   parameter int CNT_W = 3
);
   logic [CNT_W:0] duty_in;
   logic           duty_valid;
   logic           duty_ready;

   modport master (
      output duty_in,
      output duty_valid,
      input  duty_ready
   );

   modport slave (
      input  duty_in,
      input  duty_valid,
      output duty_ready
   );
endinterface

// File: rtl/count_pwm_3bit.sv
// PWM generator slaved to an upstream free-running counter, with glitch-free duty update at wrap.
// Latency: count -> pwm_out / wrap_pulse is 1 cycle; an accepted duty takes effect at the next MAX->0 wrap.
// Backpressure: duty_ready drops while a duty value waits in the one-entry buffer for the next wrap.
//
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   count       : upstream counter value, sampled each edge
//   duty        : duty handshake (slave side), duty_in / duty_valid / duty_ready
//   pwm_out     : registered (count < effective duty)
//   wrap_pulse  : one-cycle pulse after each observed MAX->0 transition
//   duty_active : duty value currently in effect
//   err_skip    : sticky, set when count jumps by anything other than 0 or +1
module count_pwm_3bit #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] count,
   count_pwm_3bit_if.slave  duty,
   output logic             pwm_out,
   output logic             wrap_pulse,
   output logic [CNT_W:0]   duty_active,
   output logic             err_skip
);

   localparam logic [CNT_W-1:0] MAX  = '1;
   localparam logic [CNT_W:0]   FULL = {1'b1, {CNT_W{1'b0}}};

   logic [CNT_W-1:0] prev;
   logic             prev_v;
   logic [CNT_W:0]   pend;
   logic             pend_v;

   logic             wrap_evt;
   logic             xfer;
   logic             err_evt;
   logic [CNT_W-1:0] prev_inc;
   logic [CNT_W:0]   duty_clamped;
   logic [CNT_W:0]   duty_eff;

   // prev_v gates both wrap and skip detection so the first sample after
   // reset is never compared against the reset value of prev.
   assign wrap_evt = prev_v && (prev == MAX) && (count == '0);

   // Held in its own CNT_W-bit net so MAX+1 wraps to 0.
   assign prev_inc = prev + 1'b1;
   assign err_evt  = prev_v && (count != prev) && (count != prev_inc);

   assign duty.duty_ready = !pend_v;
   assign xfer            = duty.duty_valid && !pend_v;
   assign duty_clamped    = (duty.duty_in > FULL) ? FULL : duty.duty_in;

   // On the wrap edge the pending value must already govern the new period's
   // first pwm sample, so bypass duty_active for that one edge.
   assign duty_eff = (wrap_evt && pend_v) ? pend : duty_active;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev        <= '0;
         prev_v      <= 1'b0;
         pend        <= '0;
         pend_v      <= 1'b0;
         duty_active <= '0;
         pwm_out     <= 1'b0;
         wrap_pulse  <= 1'b0;
         err_skip    <= 1'b0;
      end else begin
         prev       <= count;
         prev_v     <= 1'b1;
         wrap_pulse <= wrap_evt;
         pwm_out    <= ({1'b0, count} < duty_eff);

         if (wrap_evt && pend_v) begin
            duty_active <= pend;
         end

         // A transfer only happens with the buffer empty, so it never races
         // the wrap-time drain; a transfer on a wrap edge waits a full period.
         if (xfer) begin
            pend   <= duty_clamped;
            pend_v <= 1'b1;
         end else if (wrap_evt && pend_v) begin
            pend_v <= 1'b0;
         end

         if (err_evt) begin
            err_skip <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_count_pwm_3bit.sv
// Self-checking bench for count_pwm_3bit: directed scenarios plus randomized
// duty offers and count holds, compared each cycle against a period-level model.
module tb_count_pwm_3bit;

   localparam int CNT_W = 3;
   localparam int MAXV  = 7;
   localparam int FULLV = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] count;
   logic       pwm_out;
   logic       wrap_pulse;
   logic [3:0] duty_active;
   logic       err_skip;

   count_pwm_3bit_if #(.CNT_W(CNT_W)) dif ();

   count_pwm_3bit #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .count       (count),
      .duty        (dif),
      .pwm_out     (pwm_out),
      .wrap_pulse  (wrap_pulse),
      .duty_active (duty_active),
      .err_skip    (err_skip)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a pending-duty queue (at most one entry), the duty in
   // force, the previously observed count and the expected registered outputs.
   int m_q[$];
   int m_active;
   bit m_have;
   int m_last;
   bit m_err;
   bit m_pwm;
   bit m_wrap;
   int cnt_r;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_active = 0;
      m_have   = 0;
      m_last   = 0;
      m_err    = 0;
      m_pwm    = 0;
      m_wrap   = 0;
   endtask

   task automatic check_all();
      chk("pwm_out",     pwm_out,         m_pwm);
      chk("wrap_pulse",  wrap_pulse,      m_wrap);
      chk("duty_active", duty_active,     m_active);
      chk("duty_ready",  dif.duty_ready,  (m_q.size() == 0) ? 1 : 0);
      chk("err_skip",    err_skip,        m_err);
   endtask

   // One clock: drive at the falling edge (also releases reset), evaluate the
   // model for the rising edge, then compare just after it.
   task automatic step(input int c, input bit dv, input int din);
      int  duty_now;
      bit  is_wrap;
      bit  accepted;
      @(negedge clk);
      reset          = 1'b1;
      count          = c[2:0];
      dif.duty_valid = dv;
      dif.duty_in    = din[3:0];
      @(posedge clk);
      is_wrap  = m_have && (m_last == MAXV) && (c == 0);
      accepted = dv && (m_q.size() == 0);
      duty_now = (is_wrap && m_q.size() != 0) ? m_q[0] : m_active;
      m_pwm    = (c < duty_now);
      m_wrap   = is_wrap;
      if (is_wrap && m_q.size() != 0) m_active = m_q.pop_front();
      if (accepted) m_q.push_back((din > FULLV) ? FULLV : din);
      if (m_have && c != m_last && c != ((m_last + 1) % (MAXV + 1))) m_err = 1;
      m_last = c;
      m_have = 1;
      #1;
      check_all();
   endtask

   task automatic tick(input bit dv, input int din);
      step(cnt_r, dv, din);
      cnt_r = (cnt_r + 1) % (MAXV + 1);
   endtask

   task automatic go_to(input int target);
      while (cnt_r != target) tick(1'b0, 0);
   endtask

   task automatic run(input int n);
      repeat (n) tick(1'b0, 0);
   endtask

   initial begin
      reset          = 1'b0;
      count          = '0;
      dif.duty_valid = 1'b0;
      dif.duty_in    = '0;
      model_reset();
      cnt_r = 0;

      // Reset state, before any clock edge matters.
      #20;
      chk("rst_pwm",    pwm_out,        0);
      chk("rst_wrap",   wrap_pulse,     0);
      chk("rst_active", duty_active,    0);
      chk("rst_ready",  dif.duty_ready, 1);
      chk("rst_err",    err_skip,       0);

      // Free-running counter, no duty loaded.
      run(20);

      // Duty 3 offered at count 4, applied at the next wrap.
      go_to(4);
      tick(1'b1, 3);
      run(16);

      // Full duty, clamped over-range duty, zero duty.
      go_to(2); tick(1'b1, 8);  run(14);
      go_to(2); tick(1'b1, 12); run(14);
      go_to(2); tick(1'b1, 0);  run(14);

      // Second offer while pending is ignored; 5 is held until accepted.
      go_to(1);
      tick(1'b1, 3);
      repeat (24) tick(1'b1, 5);
      run(10);

      // Transfer exactly on the 7->0 edge: takes effect one period later.
      go_to(0);
      go_to(7);
      tick(1'b0, 0);
      tick(1'b1, 6);
      run(18);

      // Randomized duty offers and count holds.
      for (int i = 0; i < 200; i++) begin
         bit dv;
         int din;
         dv  = ($urandom_range(0, 3) == 0);
         din = $urandom_range(0, 15);
         if ($urandom_range(0, 7) == 0) step(cnt_r, dv, din);
         else tick(dv, din);
      end

      // Held count is fine; a 2->5 jump is a sticky error.
      go_to(5);
      step(5, 1'b0, 0);
      go_to(2);
      tick(1'b0, 0);
      cnt_r = 5;
      tick(1'b0, 0);
      step(5, 1'b0, 0);
      run(20);

      // Async reset mid-period with a pending duty in the buffer.
      go_to(2);
      tick(1'b1, 5);
      tick(1'b0, 0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      #10;
      check_all();

      // First sample after release is 6: neither a skip nor a wrap.
      cnt_r = 6;
      run(24);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/count_pwm_3bit.md
COUNT_PWM_3BIT -- requirements
Module: count_pwm_3bit

Interface
REQ-001 Parameter: CNT_W, 3, width of the incoming count; MAX = 2^CNT_W - 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 count  input  CNT_W  free-running count from the upstream synchronous up counter, sampled each rising edge.
REQ-005 duty_in  input  CNT_W+1  requested duty, in counts per period, range 0..MAX+1.
REQ-006 duty_valid  input  1  duty_in valid; transfer when duty_valid and duty_ready are both high at a rising edge.
REQ-007 duty_ready  output  1  high when the one-entry pending-duty buffer is empty.
REQ-008 pwm_out  output  1  registered PWM output.
REQ-009 wrap_pulse  output  1  one-cycle registered pulse marking a period start.
REQ-010 duty_active  output  CNT_W+1  duty value currently in effect.
REQ-011 err_skip  output  1  sticky flag: count sequence violated.

Function
REQ-012 The block SHALL register count into prev, and SHALL set prev_v, on every rising edge.
REQ-013 wrap_evt (combinational) SHALL be prev_v && prev == MAX && count == 0.
REQ-014 On a rising edge with wrap_evt, wrap_pulse SHALL be 1 for exactly one cycle; otherwise it SHALL be 0.
REQ-015 A transfer SHALL load duty_in into pend and set pend_v; duty_in > MAX+1 SHALL be clamped to MAX+1.
REQ-016 duty_ready SHALL equal !pend_v; while pend_v is high, duty_valid SHALL be ignored and duty_in may change freely.
REQ-017 On a rising edge with wrap_evt and pend_v set, duty_active SHALL load pend and pend_v SHALL clear.
REQ-018 On a wrap_evt edge with pend_v clear, duty_active SHALL hold its value.
REQ-019 Simultaneous transfer and wrap_evt: the new value SHALL go to pend and SHALL apply only at the next wrap_evt.
REQ-020 duty_eff SHALL be pend when wrap_evt && pend_v, and duty_active otherwise.
REQ-021 pwm_out SHALL register (count < duty_eff); latency from count to pwm_out is 1 cycle.
REQ-022 duty_eff of 0 SHALL hold pwm_out at 0; duty_eff of MAX+1 SHALL hold pwm_out at 1 for the whole period.
REQ-023 err_skip SHALL set when prev_v is high and count is neither prev nor (prev+1) mod 2^CNT_W.
REQ-024 err_skip SHALL stay set until reset; a held count (count == prev) is not an error.
REQ-025 The first edge after reset release SHALL NOT evaluate err_skip or wrap_evt (prev_v = 0).
REQ-026 Count arithmetic SHALL be modulo 2^CNT_W; the duty comparison SHALL be unsigned, zero-extending count to CNT_W+1 bits.

Reset
REQ-027 When reset is low, the block SHALL set: pwm_out 0, wrap_pulse 0, duty_active 0, pend 0, pend_v 0 (duty_ready 1), err_skip 0, prev 0, prev_v 0.
REQ-028 Reset asserted mid-period SHALL discard any pending duty and SHALL take effect without waiting for a clock edge.
REQ-029 After reset release, the first wrap_evt SHALL require an observed MAX->0 transition.

Verification
REQ-030 Reset low 20 ns, then release, with the upstream counter running 0..7 and no duty loaded -> pwm_out stays 0, duty_ready 1, wrap_pulse is high one cycle after each 7->0 edge.
REQ-031 Transfer duty_in = 3 while count = 4 -> duty_ready low from the next cycle; at the 7->0 edge duty_active = 3, duty_ready returns to 1, and pwm_out is high for 3 cycles, lagging counts 0, 1, 2 by one cycle.
REQ-032 duty_in = 8 -> pwm_out constantly 1 after the wrap; duty_in = 12 -> clamped, duty_active = 8; duty_in = 0 -> pwm_out constantly 0.
REQ-033 Second duty_valid (value 5) while pend_v = 1 -> not accepted and first value applied at the wrap; value 5 held until duty_ready = 1, then applied at the following wrap.
REQ-034 Force count 2->5 -> err_skip = 1 from the next edge and stays set through later clean wraps; count held 5->5 -> no error; first sample after reset = 6 -> no error.
REQ-035 Transfer at the 7->0 edge itself -> the value appears in duty_active one period later; reset low asynchronously mid-period -> all outputs 0 immediately, and the pending duty is not applied after release.
